div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start_i, input, 1 bit: divide request; the requester holds it high until it has seen ready_o=1.
REQ-004 SHALL have port annul_i, input, 1 bit: cancels an in-flight divide (pipeline flush).
REQ-005 SHALL have port signed_div_i, input, 1 bit: 1 selects signed (DIV), 0 selects unsigned (DIVU).
REQ-006 SHALL have port opdata1_i, input, 32 bits: dividend.
REQ-007 SHALL have port opdata2_i, input, 32 bits: divisor.
REQ-008 SHALL have port result_o, output, 64 bits: {remainder[63:32], quotient[31:0]}, i.e. the HI and LO values.
REQ-009 SHALL have port ready_o, output, 1 bit: 1 when result_o is valid.

Function
REQ-010 SHALL implement a 4-state FSM with states IDLE, BYZERO, ON and END.
REQ-011 In IDLE with start_i=1 and annul_i=0, SHALL capture the operands at that edge (E0).
- Divisor = 0 -> BYZERO.
- Otherwise -> ON, with iteration counter = 0.
REQ-012 In IDLE with start_i=0, or with annul_i=1, SHALL remain in IDLE.
REQ-013 For signed operation, SHALL convert each negative operand to its two's-complement magnitude before iterating; unsigned operation uses the operands unchanged.
REQ-014 In ON, SHALL perform one restoring shift-subtract step per edge, on edges E1..E32.
- Datapath: 65-bit partial-remainder/quotient register.
- Counter: 6 bits.
REQ-015 At edge E33, SHALL apply sign correction, load result_o and go to END with ready_o=1.
- Quotient is negated when signed and the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-016 Quotient and remainder arithmetic SHALL wrap modulo 2^32; 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0.
REQ-017 From BYZERO, SHALL go to END at E1 with result_o=0 and ready_o=1.
REQ-018 In END, SHALL hold result_o and ready_o=1 while start_i=1.
REQ-019 In END, when start_i=0, SHALL go to IDLE on the next edge, clearing ready_o and result_o to 0.
REQ-020 In ON or BYZERO with annul_i=1, SHALL go to IDLE on that edge with ready_o=0 and result_o=0; annul_i SHALL take priority over the iteration step.
REQ-021 In ON, a deassertion of start_i SHALL be ignored; only annul_i or rst aborts an operation.
REQ-022 ready_o SHALL be 1 only in END; result_o SHALL be 0 in IDLE, ON and BYZERO.
REQ-023 A new start_i SHALL be accepted only from IDLE, so back-to-back divides require at least one cycle with start_i=0.

Reset
REQ-024 With rst=1 at an edge, SHALL go to IDLE with result_o=0, ready_o=0 and counter 0, from any state including mid-ON.
REQ-025 rst SHALL take priority over annul_i and start_i.

Configuration
REQ-026 The macro DIV_EARLY_OUT_EN SHALL control an early-out path for small dividends.
- Defined: in IDLE on start with nonzero divisor and |dividend| < |divisor| (magnitudes per REQ-013), SHALL go directly to END at E1 with quotient 0 and remainder = opdata1_i unchanged.
- Not defined: every nonzero-divisor divide takes the full 34-edge path of REQ-014/REQ-015.

Verification
REQ-027 Unsigned 100 / 7, start held high -> ready_o=1 after E33, result_o={32'd2, 32'd14}, held until start_i=0; IDLE one edge after start_i falls.
REQ-028 Signed 0xFFFFFFF9 / 0x00000002 (-7/2) -> result_o={0xFFFFFFFF, 0xFFFFFFFD}.
REQ-029 Signed 0x80000000 / 0xFFFFFFFF -> result_o={0x00000000, 0x80000000}.
REQ-030 Divisor 0, dividend 0x12345678 -> ready_o=1 after E1, result_o=0.
REQ-031 annul_i pulsed at E10 of 100/7 -> IDLE after E10, ready_o never asserts; a new start at E12 for 9/3 -> result_o={0, 3} with full latency.
REQ-032 rst at E20 mid-divide -> outputs 0 after that edge; with DIV_EARLY_OUT_EN defined, 3 / 10 -> ready_o after E1, result_o={3, 0}.

Source files
------------

// File: rtl/div_unit.sv
// Iterative 32/32 restoring divider (DIV/DIVU), one quotient bit per clock.
// Optional build macro DIV_EARLY_OUT_EN: |dividend| < |divisor| finishes in one step.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    // state  | meaning
    // IDLE   | waiting for start_i
    // BYZERO | zero divisor (or early-out), result on next edge
    // ON     | 32 shift-subtract steps, then sign fix
    // END    | result valid, held while start_i stays high
    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [64:0] r_dividend;
    logic [31:0] r_divisor;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_early;
    logic [63:0] r_result;

    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic        w_early;
    logic        w_accept;
    logic        w_done;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_small;

    assign w_mag1   = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    assign w_mag2   = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    assign w_accept = start_i && !annul_i;
    assign w_done   = (r_cnt == 6'd32);

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (w_mag1 < w_mag2);
`else
    assign w_early = 1'b0;
`endif

    // Partial remainder lives in [64:33]; [64:32] is it shifted with the next dividend bit.
    // A successful subtract always leaves less than the divisor, so 32 bits suffice.
    assign w_ge   = (r_dividend[64:32] >= {1'b0, r_divisor});
    assign w_diff = r_dividend[63:32] - r_divisor;

    assign w_quot  = r_neg_q ? -r_dividend[31:0]  : r_dividend[31:0];
    assign w_rem   = r_neg_r ? -r_dividend[64:33] : r_dividend[64:33];
    assign w_small = r_neg_r ? -r_dividend[32:1]  : r_dividend[32:1];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (opdata2_i == 32'd0 || w_early) w_next = S_BYZERO;
                    else                               w_next = S_ON;
                end
            end
            S_BYZERO: w_next = annul_i ? S_IDLE : S_END;
            S_ON: begin
                if (annul_i)     w_next = S_IDLE;
                else if (w_done) w_next = S_END;
            end
            S_END:    if (!start_i) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 6'd0;
            r_dividend <= 65'd0;
            r_divisor  <= 32'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_early    <= 1'b0;
            r_result   <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt      <= 6'd0;
                        r_dividend <= {32'd0, w_mag1, 1'b0};
                        r_divisor  <= w_mag2;
                        r_neg_q    <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        r_neg_r    <= signed_div_i && opdata1_i[31];
                        r_early    <= w_early && (opdata2_i != 32'd0);
                    end
                end
                S_BYZERO: begin
                    if (!annul_i && r_early) r_result <= {w_small, 32'd0};
                    else                     r_result <= 64'd0;
                end
                S_ON: begin
                    if (annul_i) begin
                        r_cnt    <= 6'd0;
                        r_result <= 64'd0;
                    end else if (!w_done) begin
                        if (w_ge) r_dividend <= {w_diff, r_dividend[31:0], 1'b1};
                        else      r_dividend <= {r_dividend[63:0], 1'b0};
                        r_cnt <= r_cnt + 6'd1;
                    end else begin
                        r_result <= {w_rem, w_quot};
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        r_cnt    <= 6'd0;
                        r_result <= 64'd0;
                    end
                end
                default: r_result <= 64'd0;
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = (r_state == S_END);

endmodule
